// File: rtl/search_nanofs_chain.sv
// NanoFS directory walker: fetches entry headers one block at a time from an
// SD/SPI block reader. It follows directory child pointers and sibling next
// pointers until it finds an exact name match, a dead end or the hop limit.
module search_nanofs_chain #(
  parameter int NAME_MAX_LEN = 16,
  parameter int ADDR_W       = 32,
  parameter int MAX_HOPS     = 255,
  localparam int NL_W        = $clog2(NAME_MAX_LEN + 1),
  localparam int HOP_W       = $clog2(MAX_HOPS + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            begin_address,
  input  logic [ADDR_W-1:0]            offset,
  input  logic [NAME_MAX_LEN-1:0][7:0] filename,
  input  logic [NL_W-1:0]              name_len,
  output logic                         busy,
  output logic                         success,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [ADDR_W-1:0]            start_reg,
  output logic [HOP_W-1:0]             hops,
  output logic                         spi_r_block,
  output logic                         spi_r_byte,
  input  logic                         spi_busy,
  input  logic                         spi_err,
  output logic [ADDR_W-1:0]            spi_block_addr,
  input  logic [7:0]                   spi_data_out
);

  localparam int IDX_W = (NAME_MAX_LEN > 1) ? $clog2(NAME_MAX_LEN) : 1;

  localparam logic [1:0] E_NOT_FOUND = 2'd0;
  localparam logic [1:0] E_BAD_ENTRY = 2'd1;
  localparam logic [1:0] E_LOOP      = 2'd2;
  localparam logic [1:0] E_SPI       = 2'd3;

  // Header byte 14 is the first name byte; reaching it ends the header phase.
  localparam logic [3:0] HDR_LEN = 4'd14;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_IDLE,
    S_OPEN,
    S_WAIT_OPEN,
    S_HDR,
    S_WAIT_BYTE,
    S_CHECK,
    S_CMP,
    S_WAIT_CMP,
    S_SKIP,
    S_FOUND,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  cur_reg, cur_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [ADDR_W-1:0]  found_reg, found_next;
  logic [HOP_W-1:0]   hops_reg, hops_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [7:0]         flags_reg, flags_next;
  logic [31:0]        link_reg, link_next;
  logic [31:0]        child_reg, child_next;
  logic [7:0]         len_reg, len_next;
  logic [1:0]         err_code_reg, err_code_next;
  logic               r_block_reg, r_block_next;
  logic [NAME_MAX_LEN-1:0] name_hit;

  // Per-position compare of the current reader byte against every target byte;
  // CMP then just selects the position it is currently checking.
  generate
    for (genvar gi = 0; gi < NAME_MAX_LEN; gi++) begin : g_hit
      assign name_hit[gi] = (filename[gi] == spi_data_out);
    end
  endgenerate

  // State register and all datapath registers; reset aborts any block read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      cur_reg      <= '0;
      addr_reg     <= '0;
      found_reg    <= '0;
      hops_reg     <= '0;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      flags_reg    <= '0;
      link_reg     <= '0;
      child_reg    <= '0;
      len_reg      <= '0;
      err_code_reg <= '0;
      r_block_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_reg      <= cur_next;
      addr_reg     <= addr_next;
      found_reg    <= found_next;
      hops_reg     <= hops_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      flags_reg    <= flags_next;
      link_reg     <= link_next;
      child_reg    <= child_next;
      len_reg      <= len_next;
      err_code_reg <= err_code_next;
      r_block_reg  <= r_block_next;
    end
  end

  // Next-state, datapath updates and the combinational byte request.
  always_comb begin
    state_next    = state_reg;
    cur_next      = cur_reg;
    addr_next     = addr_reg;
    found_next    = found_reg;
    hops_next     = hops_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    flags_next    = flags_reg;
    link_next     = link_reg;
    child_next    = child_reg;
    len_next      = len_reg;
    err_code_next = err_code_reg;
    r_block_next  = r_block_reg;
    spi_r_byte    = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          cur_next   = begin_address;
          state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        r_block_next = 1'b0;
        cnt_next     = '0;
        idx_next     = '0;
        if (32'(hops_reg) >= MAX_HOPS) begin
          err_code_next = E_LOOP;
          state_next    = S_ERROR;
        end else begin
          addr_next  = cur_reg + offset;
          hops_next  = hops_reg + HOP_W'(1);
          state_next = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (spi_err) begin
          err_code_next = E_SPI;
          state_next    = S_ERROR;
        end else if (!spi_busy) begin
          r_block_next = 1'b1;
          state_next   = S_OPEN;
        end
      end

      S_OPEN: begin
        state_next = S_WAIT_OPEN;
      end

      S_WAIT_OPEN: begin
        if (spi_err) begin
          err_code_next = E_SPI;
          state_next    = S_ERROR;
        end else if (!spi_busy) begin
          state_next = S_HDR;
        end
      end

      S_HDR: begin
        // Multi-byte fields arrive LSB first, so shift new bytes in at the top.
        case (cnt_reg)
          4'd0:                   flags_next = spi_data_out;
          4'd1, 4'd2, 4'd3, 4'd4: link_next  = {spi_data_out, link_reg[31:8]};
          4'd5, 4'd6, 4'd7, 4'd8: child_next = {spi_data_out, child_reg[31:8]};
          4'd13:                  len_next   = spi_data_out;
          default: ;
        endcase
        if (cnt_reg == HDR_LEN) begin
          state_next = S_CHECK;
        end else begin
          spi_r_byte = 1'b1;
          cnt_next   = cnt_reg + 4'd1;
          state_next = S_WAIT_BYTE;
        end
      end

      S_WAIT_BYTE: begin
        if (spi_err) begin
          err_code_next = E_SPI;
          state_next    = S_ERROR;
        end else if (!spi_busy) begin
          state_next = S_HDR;
        end
      end

      S_CHECK: begin
        if (flags_reg == 8'h01) begin
          if (child_reg == '0) begin
            err_code_next = E_NOT_FOUND;
            state_next    = S_ERROR;
          end else begin
            cur_next   = ADDR_W'(child_reg);
            state_next = S_LOAD;
          end
        end else if (flags_reg == 8'h00) begin
          if (len_reg == 8'd0 || 32'(len_reg) > NAME_MAX_LEN) begin
            err_code_next = E_BAD_ENTRY;
            state_next    = S_ERROR;
          end else if (32'(len_reg) != 32'(name_len)) begin
            state_next = S_SKIP;
          end else begin
            idx_next   = '0;
            state_next = S_CMP;
          end
        end else begin
          err_code_next = E_BAD_ENTRY;
          state_next    = S_ERROR;
        end
      end

      S_CMP: begin
        if (!name_hit[idx_reg]) begin
          state_next = S_SKIP;
        end else if (32'(idx_reg) + 1 == 32'(name_len)) begin
          state_next = S_FOUND;
        end else begin
          spi_r_byte = 1'b1;
          idx_next   = idx_reg + IDX_W'(1);
          state_next = S_WAIT_CMP;
        end
      end

      S_WAIT_CMP: begin
        if (spi_err) begin
          err_code_next = E_SPI;
          state_next    = S_ERROR;
        end else if (!spi_busy) begin
          state_next = S_CMP;
        end
      end

      S_SKIP: begin
        if (link_reg == '0) begin
          err_code_next = E_NOT_FOUND;
          state_next    = S_ERROR;
        end else begin
          cur_next   = ADDR_W'(link_reg);
          state_next = S_LOAD;
        end
      end

      S_FOUND: begin
        found_next = ADDR_W'(child_reg);
        state_next = S_DONE;
      end

      S_DONE: begin
        if (!start) state_next = S_IDLE;
      end

      S_ERROR: begin
        if (!start) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase

    // The block is abandoned whenever the walk leaves the read phase.
    if (state_next == S_DONE || state_next == S_ERROR) begin
      r_block_next = 1'b0;
    end

    // Entering or staying in IDLE wipes every result so outputs read as zero.
    if (state_next == S_IDLE) begin
      cur_next      = '0;
      addr_next     = '0;
      found_next    = '0;
      hops_next     = '0;
      cnt_next      = '0;
      idx_next      = '0;
      flags_next    = '0;
      link_next     = '0;
      child_next    = '0;
      len_next      = '0;
      err_code_next = '0;
      r_block_next  = 1'b0;
    end
  end

  assign busy           = !(state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERROR);
  assign success        = (state_reg == S_DONE);
  assign err            = (state_reg == S_ERROR);
  assign err_code       = err_code_reg;
  assign start_reg      = found_reg;
  assign hops           = hops_reg;
  assign spi_r_block    = r_block_reg;
  assign spi_block_addr = addr_reg;

endmodule

// File: tb/tb_search_nanofs_chain.sv
// Self-checking bench: an SD block-reader model serves entries from a small
// block image, and a path-walking reference model predicts each search result.
module tb_search_nanofs_chain;

  localparam int NML = 16;
  localparam int AW  = 32;
  localparam int MH  = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [AW-1:0]        begin_address;
  logic [AW-1:0]        offset;
  logic [NML-1:0][7:0]  filename;
  logic [4:0]           name_len;
  logic                 busy, success, err;
  logic [1:0]           err_code;
  logic [AW-1:0]        start_reg;
  logic [2:0]           hops;
  logic                 spi_r_block, spi_r_byte;
  logic                 rd_busy;
  logic                 spi_err;
  logic [AW-1:0]        spi_block_addr;
  logic [7:0]           rd_data;

  search_nanofs_chain #(.NAME_MAX_LEN(NML), .ADDR_W(AW), .MAX_HOPS(MH)) dut (
    .clk(clk), .reset(reset), .start(start), .begin_address(begin_address),
    .offset(offset), .filename(filename), .name_len(name_len), .busy(busy),
    .success(success), .err(err), .err_code(err_code), .start_reg(start_reg),
    .hops(hops), .spi_r_block(spi_r_block), .spi_r_byte(spi_r_byte),
    .spi_busy(rd_busy), .spi_err(spi_err), .spi_block_addr(spi_block_addr),
    .spi_data_out(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [64][32];

  // Reader model state
  bit  rd_open;
  int  rd_blk, rd_ptr, rd_cnt;
  int  err_at;
  int  pulses;
  int  proto_err;
  int  visited[$];

  // Reference model results
  int          exp_vis[$];
  int          exp_res;   // 0 found, 1 error
  int          exp_code;
  int          exp_hops;
  int          exp_pulses;
  logic [31:0] exp_child;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SD reader: opens a block when spi_r_block rises, presents byte 0 after a
  // random latency, and advances one byte per spi_r_byte pulse.
  always @(negedge clk) begin
    if (reset || !spi_r_block) begin
      rd_open = 1'b0;
      rd_busy = 1'b0;
      rd_cnt  = 0;
      spi_err = 1'b0;
    end else if (!rd_open) begin
      rd_open = 1'b1;
      rd_blk  = int'(spi_block_addr - offset) & 63;
      visited.push_back(rd_blk);
      rd_ptr  = 0;
      rd_cnt  = $urandom_range(1, 3);
      rd_busy = 1'b1;
    end else if (spi_r_byte) begin
      if (rd_busy) proto_err++;
      pulses++;
      rd_ptr++;
      rd_cnt  = $urandom_range(1, 3);
      rd_busy = 1'b1;
      if (rd_ptr == err_at) spi_err = 1'b1;
    end else if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0 && !spi_err) begin
        rd_busy = 1'b0;
        rd_data = mem[rd_blk][rd_ptr & 31];
      end
    end
  end

  task automatic clear_mem();
    for (int b = 0; b < 64; b++)
      for (int i = 0; i < 32; i++) mem[b][i] = 8'h00;
  endtask

  task automatic set_entry(input int b, input logic [7:0] fl, input logic [31:0] nx,
                           input logic [31:0] ch, input string nm, input int ln);
    logic [7:0] lb;
    for (int i = 0; i < 32; i++) mem[b][i] = 8'h00;
    mem[b][0] = fl;
    for (int j = 0; j < 4; j++) begin
      mem[b][1 + j] = nx[8*j +: 8];
      mem[b][5 + j] = ch[8*j +: 8];
    end
    lb = 8'(ln);
    mem[b][13] = lb;
    for (int i = 0; i < nm.len() && i < NML; i++) mem[b][14 + i] = nm[i];
  endtask

  function automatic logic [31:0] field32(input int b, input int base);
    logic [31:0] v;
    for (int j = 0; j < 4; j++) v[8*j +: 8] = mem[b][base + j];
    return v;
  endfunction

  // Walks the image the way the file system defines a lookup.
  task automatic model(input int root, input string nm);
    int  cur, ln, nl;
    bit  done, skip, mism;
    logic [7:0] fl;
    exp_vis.delete();
    exp_hops = 0; exp_pulses = 0; exp_res = 1; exp_code = 0; exp_child = 0;
    cur = root; done = 0; nl = nm.len();
    while (!done) begin
      if (exp_hops == MH) begin
        exp_code = 2; done = 1;
      end else begin
        exp_hops++;
        exp_vis.push_back(cur);
        exp_pulses += 14;
        fl = mem[cur][0];
        ln = int'(mem[cur][13]);
        skip = 0;
        if (fl == 8'h01) begin
          if (field32(cur, 5) == 0) begin exp_code = 0; done = 1; end
          else cur = int'(field32(cur, 5)) & 63;
        end else if (fl != 8'h00 || ln == 0 || ln > NML) begin
          exp_code = 1; done = 1;
        end else if (ln != nl) begin
          skip = 1;
        end else begin
          mism = 0;
          for (int k = 0; k < nl; k++) begin
            if (!mism && mem[cur][14 + k] != nm[k]) begin
              mism = 1;
              exp_pulses += k;
            end
          end
          if (mism) skip = 1;
          else begin
            exp_pulses += nl - 1;
            exp_res = 0; exp_child = field32(cur, 5); done = 1;
          end
        end
        if (skip) begin
          if (field32(cur, 1) == 0) begin exp_code = 0; done = 1; end
          else cur = int'(field32(cur, 1)) & 63;
        end
      end
    end
  endtask

  // One search: drive request, wait for a result, compare, then release start.
  task automatic run(input string tag, input int root, input logic [31:0] off,
                     input string nm, input int inject);
    int cyc;
    @(negedge clk);
    filename = '0;
    for (int k = 0; k < nm.len(); k++) filename[k] = nm[k];
    name_len = 5'(nm.len());
    begin_address = 32'(root);
    offset = off;
    err_at = inject;
    pulses = 0;
    proto_err = 0;
    visited.delete();
    start = 1'b1;
    cyc = 0;
    while (!(success || err) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".timeout"}, 32'(cyc < 3000), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".proto"}, 32'(proto_err), 32'd0);
    if (inject > 0) begin
      chk({tag, ".err"}, 32'(err), 32'd1);
      chk({tag, ".code"}, 32'(err_code), 32'd3);
      chk({tag, ".hops"}, 32'(hops), 32'd1);
    end else begin
      model(root, nm);
      chk({tag, ".success"}, 32'(success), 32'(exp_res == 0));
      chk({tag, ".err"}, 32'(err), 32'(exp_res == 1));
      chk({tag, ".hops"}, 32'(hops), 32'(exp_hops));
      chk({tag, ".pulses"}, 32'(pulses), 32'(exp_pulses));
      chk({tag, ".nvisit"}, 32'(visited.size()), 32'(exp_vis.size()));
      for (int i = 0; i < exp_vis.size() && i < visited.size(); i++)
        chk({tag, ".visit"}, 32'(visited[i]), 32'(exp_vis[i]));
      chk({tag, ".addr"}, spi_block_addr, 32'(exp_vis[exp_vis.size() - 1]) + off);
      if (exp_res == 0) chk({tag, ".start_reg"}, start_reg, exp_child);
      else              chk({tag, ".code"}, 32'(err_code), 32'(exp_code));
    end
    $display("txn %s root=%0d name=%s success=%0d err=%0d code=%0d hops=%0d start_reg=%0h",
             tag, root, nm, success, err, err_code, hops, start_reg);
    start = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_success"}, 32'(success), 32'd0);
    chk({tag, ".idle_err"}, 32'(err), 32'd0);
    chk({tag, ".idle_hops"}, 32'(hops), 32'd0);
    chk({tag, ".idle_rblock"}, 32'(spi_r_block), 32'd0);
    err_at = 0;
  endtask

  string names [5] = '{"boot.bin", "boot.bi", "a.bin", "boot.bix", "b"};

  initial begin
    int cyc, b, r, ln;
    string nm;
    logic [7:0] fl;
    reset = 1'b1; start = 1'b0; begin_address = '0; offset = '0;
    filename = '0; name_len = '0; err_at = 0; pulses = 0; proto_err = 0;
    rd_data = 8'h00; rd_busy = 1'b0; spi_err = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.success", 32'(success), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.code", 32'(err_code), 32'd0);
    chk("rst.start_reg", start_reg, 32'd0);
    chk("rst.hops", 32'(hops), 32'd0);
    chk("rst.rblock", 32'(spi_r_block), 32'd0);
    chk("rst.rbyte", 32'(spi_r_byte), 32'd0);
    chk("rst.addr", spi_block_addr, 32'd0);
    reset = 1'b0;

    // Single file at the root
    clear_mem();
    set_entry(10, 8'h00, 0, 32'h40, "boot.bin", 8);
    run("root_file", 10, 32'h2000, "boot.bin", 0);
    chk("root_file.addr_const", spi_block_addr, 32'h0);

    // Directory then sibling chain
    clear_mem();
    set_entry(10, 8'h01, 0, 20, "", 0);
    set_entry(20, 8'h00, 21, 32'h11, "a.bin", 5);
    set_entry(21, 8'h00, 0, 32'h55, "boot.bin", 8);
    run("dir_chain", 10, 32'h2000, "boot.bin", 0);

    // Last sibling mismatches
    clear_mem();
    set_entry(10, 8'h00, 0, 32'h40, "boot.bix", 8);
    run("not_found", 10, 32'h0, "boot.bin", 0);

    // Bad flags, zero length, length-mismatch skip
    clear_mem();
    set_entry(10, 8'h07, 0, 32'h40, "boot.bin", 8);
    run("bad_flags", 10, 32'h100, "boot.bin", 0);
    clear_mem();
    set_entry(10, 8'h00, 0, 32'h40, "boot.bin", 0);
    run("bad_len", 10, 32'h100, "boot.bin", 0);
    clear_mem();
    set_entry(10, 8'h00, 11, 32'h40, "boot.bi", 7);
    set_entry(11, 8'h00, 0, 32'h77, "boot.bin", 8);
    run("len_skip", 10, 32'h100, "boot.bin", 0);

    // Sibling loop hits the hop limit
    clear_mem();
    set_entry(30, 8'h00, 31, 0, "x.bin", 5);
    set_entry(31, 8'h00, 30, 0, "y.bin", 5);
    run("loop", 30, 32'h0, "boot.bin", 0);

    // Reader error during the fifth byte wait
    clear_mem();
    set_entry(10, 8'h00, 0, 32'h40, "boot.bin", 8);
    run("spi_err", 10, 32'h0, "boot.bin", 5);

    // Reset in the middle of the name compare
    @(negedge clk);
    filename = '0;
    for (int k = 0; k < 8; k++) filename[k] = names[0][k];
    name_len = 5'd8; begin_address = 32'd10; offset = 32'h2000;
    err_at = 0; start = 1'b1;
    cyc = 0;
    while (!(rd_open && rd_ptr >= 16) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_rst.reach_cmp", 32'(cyc < 3000), 32'd1);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("mid_rst.rblock", 32'(spi_r_block), 32'd0);
    chk("mid_rst.busy", 32'(busy), 32'd0);
    chk("mid_rst.hops", 32'(hops), 32'd0);
    chk("mid_rst.addr", spi_block_addr, 32'd0);
    chk("mid_rst.success", 32'(success), 32'd0);
    $display("txn mid_reset rblock=%0d busy=%0d hops=%0d", spi_r_block, busy, hops);
    reset = 1'b0;

    // Randomised images over blocks 1..7
    for (int t = 0; t < 25; t++) begin
      clear_mem();
      for (b = 1; b < 8; b++) begin
        r  = $urandom_range(0, 99);
        fl = (r < 65) ? 8'h00 : (r < 90) ? 8'h01 : 8'h05;
        nm = names[$urandom_range(0, 4)];
        r  = $urandom_range(0, 9);
        ln = (r == 0) ? 0 : (r == 1) ? 20 : nm.len();
        set_entry(b, fl, 32'($urandom_range(0, 7)),
                  (fl == 8'h01) ? 32'($urandom_range(0, 7)) : $urandom, nm, ln);
      end
      run($sformatf("rand%0d", t), $urandom_range(1, 7), $urandom,
          names[$urandom_range(0, 4)], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
